// File: rtl/trap_pkg.sv
// trap_pkg: state encoding, trap_type codes and mcause values shared by the trap controller.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4,
        HALT     = 3'd5
    } state_t;

    localparam logic [2:0] TRAP_NONE    = 3'd0;
    localparam logic [2:0] TRAP_LSAF    = 3'd1;
    localparam logic [2:0] TRAP_ILLEGAL = 3'd2;
    localparam logic [2:0] TRAP_IAF     = 3'd3;

    localparam int unsigned CAUSE_IAF     = 1;
    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_LAF     = 5;

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: trap-detection inputs and pipeline control outputs of the trap controller.
interface trap_controller_if #(
    parameter int XLEN = 64
);
    logic [2:0]      trap_type;
    logic [XLEN-1:0] mepc_in;
    logic [XLEN-1:0] mtvec_addr;
    logic            mret;
    logic            flush_if;
    logic            flush_id;
    logic            flush_ex;
    logic            flush_mem;
    logic            stall_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            in_trap;
    logic            halted;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mepc_q;

    modport slave (
        input  trap_type, mepc_in, mtvec_addr, mret,
        output flush_if, flush_id, flush_ex, flush_mem, stall_pc,
               redirect_valid, redirect_pc, in_trap, halted, mcause_q, mepc_q
    );

    modport master (
        output trap_type, mepc_in, mtvec_addr, mret,
        input  flush_if, flush_id, flush_ex, flush_mem, stall_pc,
               redirect_valid, redirect_pc, in_trap, halted, mcause_q, mepc_q
    );
endinterface

// File: rtl/trap_cause_map.sv
// trap_cause_map: maps a trap_type code to its mcause value; reserved codes read as illegal instruction.
module trap_cause_map
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      trap_type,
    output logic [XLEN-1:0] cause
);
    always_comb cause = (trap_type == TRAP_LSAF) ? XLEN'(CAUSE_LAF) :
                        (trap_type == TRAP_IAF)  ? XLEN'(CAUSE_IAF) : XLEN'(CAUSE_ILLEGAL);
endmodule

// File: rtl/trap_controller.sv
// trap_controller: trap FSM driving stage flushes, fetch redirect and the mcause/mepc CSRs.
// Defining TRAP_CONTROLLER_COUNT_EN adds saturating per-cause trap counters.
module trap_controller
    import trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN = 64
) (
    input  logic clk,
    input  logic rst,
    trap_controller_if.slave tif
`ifdef TRAP_CONTROLLER_COUNT_EN
    ,
    output logic [31:0] trap_count_load,
    output logic [31:0] trap_count_illegal,
    output logic [31:0] trap_count_inst
`endif
);
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] target_q, mcause_r, mepc_r, cause;
    logic            take;

    assign take         = (state_q == IDLE) && (tif.trap_type != TRAP_NONE);
    assign tif.mcause_q = mcause_r;
    assign tif.mepc_q   = mepc_r;

    trap_cause_map #(.XLEN(XLEN)) u_cause (
        .trap_type (tif.trap_type),
        .cause     (cause)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            mcause_r <= '0;
            mepc_r   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                cnt_q    <= CNT_INIT;
                target_q <= tif.mtvec_addr;
                mcause_r <= cause;
            end else if (state_q == FLUSH && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // mepc arrives registered, so it is valid only in the first flush cycle
            if (state_q == FLUSH && cnt_q == CNT_INIT)
                mepc_r <= tif.mepc_in;
        end
    end

    always_comb begin
        state_d            = state_q;
        tif.flush_if       = 1'b0;
        tif.flush_id       = 1'b0;
        tif.flush_ex       = 1'b0;
        tif.flush_mem      = 1'b0;
        tif.stall_pc       = 1'b0;
        tif.redirect_valid = 1'b0;
        tif.redirect_pc    = '0;
        tif.in_trap        = 1'b0;
        tif.halted         = 1'b0;
        case (state_q)
            IDLE: state_d = take ? FLUSH : IDLE;
            FLUSH: begin
                {tif.flush_if, tif.flush_id, tif.flush_ex, tif.flush_mem, tif.stall_pc} = '1;
                state_d = (cnt_q == 4'd0) ? REDIRECT : FLUSH;
            end
            REDIRECT: begin
                tif.redirect_valid = 1'b1;
                tif.redirect_pc    = target_q;
                tif.flush_if       = 1'b1;
                state_d            = HANDLER;
            end
            HANDLER: begin
                tif.in_trap = 1'b1;
                // a second trap inside the handler is a double fault, even alongside mret
                state_d = (tif.trap_type != TRAP_NONE) ? HALT : tif.mret ? RETURN : HANDLER;
            end
            RETURN: begin
                tif.redirect_valid = 1'b1;
                tif.redirect_pc    = mepc_r;
                tif.flush_if       = 1'b1;
                tif.flush_id       = 1'b1;
                tif.in_trap        = 1'b1;
                state_d            = IDLE;
            end
            HALT: {tif.flush_if, tif.flush_id, tif.flush_ex, tif.flush_mem, tif.stall_pc, tif.halted} = '1;
            default: state_d = IDLE;
        endcase
    end

`ifdef TRAP_CONTROLLER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count_load    <= '0;
            trap_count_illegal <= '0;
            trap_count_inst    <= '0;
        end else if (take) begin
            if (tif.trap_type == TRAP_LSAF && trap_count_load != '1)
                trap_count_load <= trap_count_load + 32'd1;
            if (tif.trap_type == TRAP_IAF && trap_count_inst != '1)
                trap_count_inst <= trap_count_inst + 32'd1;
            if (tif.trap_type != TRAP_LSAF && tif.trap_type != TRAP_IAF && trap_count_illegal != '1)
                trap_count_illegal <= trap_count_illegal + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed checks of the trap FSM, CSRs, double fault and reset behaviour.
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    trap_controller_if #(.XLEN(64)) tif ();

`ifdef TRAP_CONTROLLER_COUNT_EN
    logic [31:0] cnt_load, cnt_illegal, cnt_inst;
`endif

    trap_controller #(.FLUSH_CYCLES(2), .XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
`ifdef TRAP_CONTROLLER_COUNT_EN
        ,
        .trap_count_load    (cnt_load),
        .trap_count_illegal (cnt_illegal),
        .trap_count_inst    (cnt_inst)
`endif
    );

    always #5 clk = ~clk;

    // {flush_if, flush_id, flush_ex, flush_mem, stall_pc, redirect_valid, in_trap, halted}
    logic [7:0] outv;
    assign outv = {tif.flush_if, tif.flush_id, tif.flush_ex, tif.flush_mem,
                   tif.stall_pc, tif.redirect_valid, tif.in_trap, tif.halted};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_trap(input logic [2:0] t, input logic [63:0] tvec,
                            input logic [63:0] epc, input logic [63:0] exp_cause);
        tif.trap_type  = t;
        tif.mtvec_addr = tvec;
        step();
        tif.trap_type  = 3'd0;
        tif.mtvec_addr = 64'hbad0;
        tif.mepc_in    = epc;
        check("flush1", 64'(outv), 64'hF8);
        step();
        tif.mepc_in = ~epc;
        check("flush2", 64'(outv), 64'hF8);
        check("mepc", tif.mepc_q, epc);
        check("mcause", tif.mcause_q, exp_cause);
        step();
        check("redirect", 64'(outv), 64'h84);
        check("redirect_pc", tif.redirect_pc, tvec);
        step();
        check("handler", 64'(outv), 64'h02);
        check("handler_pc", tif.redirect_pc, 64'h0);
    endtask

    task automatic do_ret(input logic [63:0] epc);
        tif.mret = 1'b1;
        step();
        tif.mret = 1'b0;
        check("return", 64'(outv), 64'hC6);
        check("return_pc", tif.redirect_pc, epc);
        step();
        check("idle", 64'(outv), 64'h00);
    endtask

    initial begin
        tif.trap_type  = 3'd0;
        tif.mepc_in    = '0;
        tif.mtvec_addr = '0;
        tif.mret       = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_out", 64'(outv), 64'h0);
        check("reset_pc", tif.redirect_pc, 64'h0);
        check("reset_mcause", tif.mcause_q, 64'h0);
        check("reset_mepc", tif.mepc_q, 64'h0);

        tif.mret = 1'b1;
        step();
        tif.mret = 1'b0;
        check("mret_idle", 64'(outv), 64'h0);

        run_trap(3'd2, 64'd480, 64'h104, 64'd2);
        do_ret(64'h104);
        run_trap(3'd1, 64'd472, 64'h200, 64'd5);
        do_ret(64'h200);
        run_trap(3'd3, 64'd488, 64'h300, 64'd1);
        do_ret(64'h300);
        run_trap(3'd5, 64'd500, 64'h400, 64'd2);
        do_ret(64'h400);

        run_trap(3'd1, 64'd472, 64'h500, 64'd5);
        tif.trap_type = 3'd3;
        tif.mret      = 1'b1;
        step();
        tif.trap_type = 3'd0;
        tif.mret      = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("halt", 64'(outv), 64'hF9);
            tif.mret = (i == 3);
            step();
        end
        tif.mret = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_out", 64'(outv), 64'h0);
        check("halt_rst_mcause", tif.mcause_q, 64'h0);
        check("halt_rst_mepc", tif.mepc_q, 64'h0);

        tif.trap_type  = 3'd2;
        tif.mtvec_addr = 64'd480;
        step();
        tif.trap_type = 3'd0;
        tif.mepc_in   = 64'h104;
        step();
        check("mid_flush", 64'(outv), 64'hF8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush_rst_out", 64'(outv), 64'h0);
        check("flush_rst_pc", tif.redirect_pc, 64'h0);
        check("flush_rst_mcause", tif.mcause_q, 64'h0);
        step();
        check("flush_rst_noredir", 64'(outv), 64'h0);

        for (int i = 0; i < 3; i++) begin
            run_trap(3'd2, 64'd480, 64'h600, 64'd2);
            do_ret(64'h600);
        end
        run_trap(3'd6, 64'd480, 64'h700, 64'd2);
        do_ret(64'h700);
`ifdef TRAP_CONTROLLER_COUNT_EN
        check("cnt_illegal", 64'(cnt_illegal), 64'd4);
        check("cnt_load", 64'(cnt_load), 64'd0);
        check("cnt_inst", 64'(cnt_inst), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
